// File: rtl/tinker_fetch_queue_if.sv
// Fetch-queue bus bundle: memory read port plus decoder-side instruction handshake.
// master = fetch queue, slave = the memory/decoder side facing it.
interface tinker_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  // Memory read port
  logic              mem_req;
  logic [63:0]       mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  // Decoder handshake
  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [63:0]       inst_pc;
  logic              inst_ready;
  logic [CountW-1:0] queue_count;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready,
    output queue_count
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready,
    input  queue_count
  );
endinterface

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: sequential 32-bit fetches from RESET_PC, one request
// outstanding at a time, results buffered with their PCs for the decoder.
// Redirects flush the queue and squash any in-flight response.
module tinker_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  input  logic                  halt,
  tinker_fetch_queue_if.master  bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic [63:0]       fetch_pc_q;
  logic              pending_q;
  logic              discard_q;
  logic [63:0]       pending_pc_q;

  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CountW-1:0] count_q;
  logic [63:0]       fifo_pc_q   [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];

  // Last head shown, so the outputs hold steady once the queue empties
  logic [63:0]       hold_pc_q;
  logic [31:0]       hold_data_q;

  logic not_empty;
  logic has_space;
  logic issue;
  logic grant;
  logic push;
  logic inst_valid;
  logic pop;

  // Issue/handshake decode
  always_comb begin
    not_empty  = (count_q != '0);
    has_space  = (count_q < CountW'(DEPTH));
    issue      = !reset && !redirect_valid && !halt && !pending_q && has_space;
    grant      = issue && bus.mem_gnt;
    // A redirect squashes a same-cycle response even if it is not marked discard
    push       = bus.mem_rvalid && pending_q && !discard_q && !redirect_valid;
    inst_valid = not_empty && !redirect_valid;
    pop        = inst_valid && bus.inst_ready;
  end

  assign bus.mem_req     = issue;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.inst_valid  = inst_valid;
  assign bus.inst_pc     = not_empty ? fifo_pc_q[rd_ptr_q]   : hold_pc_q;
  assign bus.inst_data   = not_empty ? fifo_data_q[rd_ptr_q] : hold_data_q;
  assign bus.queue_count = count_q;

  // Fetch PC and single outstanding-request tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      discard_q    <= 1'b0;
      pending_pc_q <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[63:2], 2'b00};
      if (pending_q) begin
        if (bus.mem_rvalid) begin
          pending_q <= 1'b0;
          discard_q <= 1'b0;
        end else begin
          discard_q <= 1'b1;
        end
      end
    end else begin
      if (grant) begin
        pending_q    <= 1'b1;
        pending_pc_q <= fetch_pc_q;
        fetch_pc_q   <= fetch_pc_q + 64'd4;
      end
      if (bus.mem_rvalid && pending_q) begin
        pending_q <= 1'b0;
        discard_q <= 1'b0;
      end
    end
  end

  // FIFO pointers, occupancy and held head value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      hold_pc_q   <= '0;
      hold_data_q <= '0;
    end else begin
      if (not_empty) begin
        hold_pc_q   <= fifo_pc_q[rd_ptr_q];
        hold_data_q <= fifo_data_q[rd_ptr_q];
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CountW'(1);
        else if (!push && pop) count_q <= count_q - CountW'(1);
      end
    end
  end

  // FIFO storage; contents are only observed through count/pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pending_pc_q;
      fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for tinker_fetch_queue: a small memory responder (word = address,
// optional hold-off) plus a handshake log, checked against hand-computed values.
module tb_tinker_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;

  tinker_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  tinker_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (64'h2000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle;
  int          gnt_cnt;
  bit          auto_resp;
  bit          outstanding;
  logic [63:0] out_addr;
  logic [63:0] log_pc   [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] log_pc_at(input int i);
    return (i < log_pc.size()) ? log_pc[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] log_data_at(input int i);
    return (i < log_data.size()) ? {32'h0, log_data[i]} : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int log_cyc_at(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100;
  endfunction

  // One clock: sample this cycle's handshakes, then set memory response for the next
  task automatic step();
    logic        g;
    logic        rv;
    logic [63:0] a;
    #1;
    g  = bus.mem_req && bus.mem_gnt;
    rv = bus.mem_rvalid;
    a  = bus.mem_addr;
    if (bus.inst_valid && bus.inst_ready) begin
      log_pc.push_back(bus.inst_pc);
      log_data.push_back(bus.inst_data);
      log_cyc.push_back(cycle);
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (rv) outstanding = 1'b0;
    if (g) begin
      outstanding = 1'b1;
      out_addr    = a;
      gnt_cnt++;
    end
    if (auto_resp && outstanding) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = out_addr[31:0];
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
  endtask

  task automatic assert_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.inst_ready = 1'b0;
    auto_resp      = 1'b1;
    outstanding    = 1'b0;
    gnt_cnt        = 0;
    log_pc.delete();
    log_data.delete();
    log_cyc.delete();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset values, then zero-wait streaming at one instruction per 2 cycles
    assert_reset();
    check_val("rst mem_req", bus.mem_req, 0);
    check_val("rst mem_addr", bus.mem_addr, 64'h2000);
    check_val("rst inst_valid", bus.inst_valid, 0);
    check_val("rst inst_data", bus.inst_data, 0);
    check_val("rst inst_pc", bus.inst_pc, 0);
    check_val("rst count", bus.queue_count, 0);
    release_reset();
    bus.inst_ready = 1'b1;
    #1;
    check_val("t1 first req", bus.mem_req, 1);
    check_val("t1 first addr", bus.mem_addr, 64'h2000);
    repeat (7) step();
    check_val("t1 n_delivered", log_pc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t1 pc%0d", i), log_pc_at(i), 64'h2000 + 64'(4 * i));
      check_val($sformatf("t1 data%0d", i), log_data_at(i), 64'h2000 + 64'(4 * i));
      check_val($sformatf("t1 cyc%0d", i), 64'(log_cyc_at(i)), 64'(2 + 2 * i));
    end

    // T2: reset mid-operation, stale response after release, fill to DEPTH, drain
    assert_reset();
    check_val("t2 rst count", bus.queue_count, 0);
    check_val("t2 rst inst_valid", bus.inst_valid, 0);
    check_val("t2 rst mem_req", bus.mem_req, 0);
    release_reset();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    repeat (20) step();
    check_val("t2 grants", gnt_cnt, 4);
    check_val("t2 mem_req idle", bus.mem_req, 0);
    check_val("t2 full count", bus.queue_count, 4);
    check_val("t2 head pc", bus.inst_pc, 64'h2000);
    check_val("t2 head data", bus.inst_data, 64'h2000);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 20 && log_pc.size() < 4; i++) step();
    check_val("t2 n_drained", (log_pc.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t2 pc%0d", i), log_pc_at(i), 64'h2000 + 64'(4 * i));
      check_val($sformatf("t2 data%0d", i), log_data_at(i), 64'h2000 + 64'(4 * i));
    end

    // T3: redirect to 0x3002 while 0x2008 is outstanding
    assert_reset();
    release_reset();
    for (int i = 0; i < 20 && gnt_cnt < 3; i++) step();
    check_val("t3 setup grants", gnt_cnt, 3);
    check_val("t3 outstanding addr", out_addr, 64'h2008);
    auto_resp      = 1'b0;
    bus.mem_rvalid = 1'b0;
    check_val("t3 pre count", bus.queue_count, 2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3002;
    #1;
    check_val("t3 redir inst_valid", bus.inst_valid, 0);
    check_val("t3 redir mem_req", bus.mem_req, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    check_val("t3 flushed count", bus.queue_count, 0);
    check_val("t3 wait discard", bus.mem_req, 0);
    check_val("t3 fetch addr", bus.mem_addr, 64'h3000);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0BAD;
    step();
    check_val("t3 stale dropped", bus.queue_count, 0);
    check_val("t3 resume req", bus.mem_req, 1);
    check_val("t3 resume addr", bus.mem_addr, 64'h3000);
    auto_resp      = 1'b1;
    bus.inst_ready = 1'b1;
    log_pc.delete();
    log_data.delete();
    log_cyc.delete();
    for (int i = 0; i < 10 && log_pc.size() < 1; i++) step();
    check_val("t3 first pc", log_pc_at(0), 64'h3000);
    check_val("t3 first data", log_data_at(0), 64'h3000);

    // T4: redirect coinciding with a response and a would-be pop
    assert_reset();
    release_reset();
    repeat (3) step();
    check_val("t4 pre count", bus.queue_count, 1);
    bus.inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    step();
    redirect_valid = 1'b0;
    #1;
    check_val("t4 count", bus.queue_count, 0);
    check_val("t4 no pop", log_pc.size(), 0);
    check_val("t4 req", bus.mem_req, 1);
    check_val("t4 addr", bus.mem_addr, 64'h4000);

    // T5: halt with one request in flight
    assert_reset();
    release_reset();
    bus.inst_ready = 1'b1;
    step();
    halt = 1'b1;
    #1;
    check_val("t5 halted req", bus.mem_req, 0);
    repeat (8) step();
    check_val("t5 grants", gnt_cnt, 1);
    check_val("t5 delivered", log_pc.size(), 1);
    check_val("t5 pc", log_pc_at(0), 64'h2000);
    check_val("t5 count", bus.queue_count, 0);
    halt = 1'b0;
    #1;
    check_val("t5 resume req", bus.mem_req, 1);
    check_val("t5 resume addr", bus.mem_addr, 64'h2004);

    // T6: fetch PC wraps past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    #1;
    check_val("t6 req", bus.mem_req, 1);
    check_val("t6 top addr", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check_val("t6 wrap addr", bus.mem_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
